// File: rtl/blink_tweakey_sched.sv
// Iterative round-tweakey generator for the Blink_64a datapath.
// Optional tweak input enabled by defining BLINK_TWEAK_INPUT_EN.
module blink_tweakey_sched #(
    parameter int unsigned ROUNDS  = 16,
    parameter logic [5:0]  RC_INIT = 6'h01
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key_in,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic         abort,
`ifdef BLINK_TWEAK_INPUT_EN
    input  logic [63:0]  tweak_in,
`endif
    output logic [63:0]  tk,
    output logic         tk_valid,
    input  logic         tk_ready,
    output logic [5:0]   round_idx,
    output logic         tk_last
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [5:0] LAST_RND = 6'(ROUNDS - 1);

    state_t       state, state_nxt;
    logic [127:0] s;
    logic [5:0]   rc;
    logic [5:0]   rnd;
    logic         load;
    logic         adv;
    logic         is_last;
    logic         run;

`ifdef BLINK_TWEAK_INPUT_EN
    logic [63:0]  t;
`endif

    assign run     = (state == RUN);
    assign is_last = (rnd == LAST_RND);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // abort outranks both a load in IDLE and an accept in RUN
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        adv       = 1'b0;
        key_ready = 1'b0;
        tk_valid  = 1'b0;
        case (state)
            IDLE: begin
                key_ready = 1'b1;
                if (key_valid && !abort) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                tk_valid = 1'b1;
                if (abort) begin
                    state_nxt = IDLE;
                end else if (tk_ready) begin
                    if (is_last) begin
                        state_nxt = IDLE;
                    end else begin
                        adv = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s   <= '0;
            rc  <= RC_INIT;
            rnd <= '0;
        end else if (load) begin
            s   <= key_in;
            rc  <= RC_INIT;
            rnd <= '0;
        end else if (adv) begin
            s[127:64] <= s[63:0];
            s[63:0]   <= {s[123:64], s[127:124]} ^ {60'b0, rnd[3:0]};
            rc        <= {rc[4:0], rc[5] ^ rc[4] ^ 1'b1};
            rnd       <= rnd + 6'd1;
        end
    end

`ifdef BLINK_TWEAK_INPUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t <= '0;
        end else if (load) begin
            t <= tweak_in;
        end else if (adv) begin
            t <= {t[59:0], t[63:60]};
        end
    end

    assign tk = run ? (s[127:64] ^ t ^ {58'b0, rc}) : '0;
`else
    assign tk = run ? (s[127:64] ^ {58'b0, rc}) : '0;
`endif

    // round info is only meaningful while a key is being presented
    assign round_idx = run ? rnd : '0;
    assign tk_last   = run && is_last;

endmodule

// File: tb/tb_blink_tweakey_sched.sv
// Self-checking bench for blink_tweakey_sched against an arithmetic key-schedule model.
module tb_blink_tweakey_sched;

    logic         clk;
    logic         rst;
    logic [127:0] key_in;
    logic         key_valid;
    logic         key_ready;
    logic         abort;
    logic [63:0]  tk;
    logic         tk_valid;
    logic         tk_ready;
    logic [5:0]   round_idx;
    logic         tk_last;

    int ntests = 0;
    int nfail  = 0;
    logic [63:0] exp_tk [0:15];

`ifdef BLINK_TWEAK_INPUT_EN
    logic [63:0] tweak_in;
    assign tweak_in = '0;
`endif

    blink_tweakey_sched #(.ROUNDS(16), .RC_INIT(6'h01)) dut (
        .clk(clk), .rst(rst), .key_in(key_in), .key_valid(key_valid),
        .key_ready(key_ready), .abort(abort),
`ifdef BLINK_TWEAK_INPUT_EN
        .tweak_in(tweak_in),
`endif
        .tk(tk), .tk_valid(tk_valid), .tk_ready(tk_ready),
        .round_idx(round_idx), .tk_last(tk_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        ntests++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Schedule model: hi/lo halves, hi rotated by 4 bits and xored with the round number
    task automatic compute(input logic [127:0] key);
        logic [63:0] hi, lo, nlo;
        int unsigned rcv;
        hi  = key[127:64];
        lo  = key[63:0];
        rcv = 1;
        for (int r = 0; r < 16; r++) begin
            exp_tk[r] = hi ^ 64'(rcv);
            nlo = ((hi << 4) | (hi >> 60)) ^ 64'(r % 16);
            hi  = lo;
            lo  = nlo;
            rcv = ((rcv * 2) % 64) + ((((rcv / 32) % 2) + ((rcv / 16) % 2) + 1) % 2);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [127:0] k);
        key_in    = k;
        key_valid = 1'b1;
        step();
        key_valid = 1'b0;
    endtask

    task automatic check_round(input int r);
        chk("tk_valid", 64'(tk_valid), 64'd1);
        chk("key_ready_run", 64'(key_ready), 64'd0);
        chk($sformatf("tk_r%0d", r), tk, exp_tk[r]);
        chk("round_idx", 64'(round_idx), 64'(r));
        chk("tk_last", 64'(tk_last), 64'(r == 15));
    endtask

    task automatic rounds(input int lo, input int hi);
        for (int r = lo; r < hi; r++) begin
            check_round(r);
            step();
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_tk_valid"}, 64'(tk_valid), 64'd0);
        chk({tag, "_key_ready"}, 64'(key_ready), 64'd1);
        chk({tag, "_tk"}, tk, 64'd0);
        chk({tag, "_tk_last"}, 64'(tk_last), 64'd0);
    endtask

    initial begin
        logic [127:0] k;
        rst = 1'b1; key_in = '0; key_valid = 1'b0; abort = 1'b0; tk_ready = 1'b1;
        #1;
        check_idle("reset");
        chk("reset_round_idx", 64'(round_idx), 64'd0);
        step(); step();
        rst = 1'b0;
        step();
        check_idle("post_reset");

        // all-zero key: constants straight from the rc sequence
        compute('0);
        load('0);
        chk("zero_r0_const", tk, 64'h1);
        step();
        chk("zero_r1_const", tk, 64'h3);
        rounds(1, 16);
        check_idle("zero_done");

        // alternating pattern key
        k = {64'hAAAAAAAAAAAAAAAA, 64'h5555555555555555};
        compute(k);
        load(k);
        chk("alt_r0_const", tk, 64'hAAAAAAAAAAAAAAAB);
        step();
        chk("alt_r1_const", tk, 64'h5555555555555556);
        rounds(1, 16);
        check_idle("alt_done");

        // backpressure at round 2
        k = {$urandom, $urandom, $urandom, $urandom};
        compute(k);
        load(k);
        rounds(0, 2);
        tk_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check_round(2);
        end
        tk_ready = 1'b1;
        rounds(2, 16);
        check_idle("bp_done");

        // abort with simultaneous accept at round 7, then restart
        k = {$urandom, $urandom, $urandom, $urandom};
        compute(k);
        load(k);
        rounds(0, 7);
        check_round(7);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_idle("abort");
        abort = 1'b1; key_in = k; key_valid = 1'b1;
        step();
        abort = 1'b0; key_valid = 1'b0;
        check_idle("abort_blocks_load");
        k = {$urandom, $urandom, $urandom, $urandom};
        compute(k);
        load(k);
        rounds(0, 16);
        check_idle("restart_done");

        // asynchronous reset between edges during round 5
        k = {$urandom, $urandom, $urandom, $urandom};
        compute(k);
        load(k);
        rounds(0, 5);
        #2;
        rst = 1'b1;
        #1;
        check_idle("async_rst");
        step();
        rst = 1'b0;
        step();
        check_idle("after_async_rst");

        // key_valid during RUN is ignored
        k = {$urandom, $urandom, $urandom, $urandom};
        compute(k);
        load(k);
        rounds(0, 3);
        key_in = ~k;
        key_valid = 1'b1;
        rounds(3, 8);
        key_valid = 1'b0;
        rounds(8, 16);
        check_idle("kv_ignored_done");

        // random key sweep
        for (int n = 0; n < 50; n++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            compute(k);
            load(k);
            rounds(0, 16);
            check_idle("sweep_done");
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
